muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and small op-decode helpers.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL   = 3'b000,
      OP_MLA   = 3'b001,
      OP_UMULL = 3'b010,
      OP_SMULL = 3'b011,
      OP_UDIV  = 3'b100,
      OP_SDIV  = 3'b101
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   function automatic logic op_is_div(input logic [2:0] i_op);
      return (i_op == OP_UDIV) || (i_op == OP_SDIV);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] i_op);
      return (i_op == OP_SMULL) || (i_op == OP_SDIV);
   endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and
// for the final sign correction of products, quotients and remainders.
module muldiv_negate #(
   parameter int W = 32
) (
   input  logic         i_neg,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit with tag tracking.
// One step per RUN cycle; signed ops work on magnitudes and fix up in FIX.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [TAG_W-1:0] tag_out,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = 2 * WIDTH + 1;

   state_t             r_state, w_next;
   logic [CW-1:0]      r_cnt;
   logic [2:0]         r_op;
   logic               r_sa, r_sb, r_dz;
   logic [WIDTH-1:0]   r_opnd, r_acc;
   logic [TAG_W-1:0]   r_tag;
   logic [PW-1:0]      r_p;

   logic               r_done, r_div_zero;
   logic [WIDTH-1:0]   r_lo, r_hi;
   logic [TAG_W-1:0]   r_tag_out;

   logic               w_accept, w_b_zero, w_sgn, w_div;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic [WIDTH:0]     w_add_hi;
   logic [PW-1:0]      w_mul_step, w_shl, w_div_step, w_step, w_fix;
   logic [WIDTH+1:0]   w_diff;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_q_fix, w_r_fix;

   assign w_accept = start && !flush;
   assign w_div    = op_is_div(op);
   assign w_sgn    = op_is_signed(op);
   assign w_b_zero = w_div && (b == '0);

   muldiv_negate #(.W(WIDTH)) u_mag_a (
      .i_neg(w_sgn && a[WIDTH-1]), .i_val(a), .o_val(w_mag_a));
   muldiv_negate #(.W(WIDTH)) u_mag_b (
      .i_neg(w_sgn && b[WIDTH-1]), .i_val(b), .o_val(w_mag_b));

   // Multiply: P = {partial(W+1), multiplier(W)}, add then shift right.
   assign w_add_hi   = r_p[PW-1:WIDTH] + {1'b0, r_opnd};
   assign w_mul_step = {(r_p[0] ? w_add_hi : r_p[PW-1:WIDTH]), r_p[WIDTH-1:0]} >> 1;

   // Divide: P = {remainder(W+1), quotient(W)}, shift left then trial subtract.
   assign w_shl      = {r_p[PW-2:0], 1'b0};
   assign w_diff     = {1'b0, w_shl[PW-1:WIDTH]} - {2'b00, r_opnd};
   assign w_div_step = w_diff[WIDTH+1] ? w_shl
                                       : {w_diff[WIDTH:0], w_shl[WIDTH-1:1], 1'b1};

   assign w_step = op_is_div(r_op) ? w_div_step : w_mul_step;

   muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
      .i_neg(r_sa ^ r_sb), .i_val(r_p[2*WIDTH-1:0]), .o_val(w_prod_fix));
   muldiv_negate #(.W(WIDTH)) u_fix_q (
      .i_neg(r_sa ^ r_sb), .i_val(r_p[WIDTH-1:0]), .o_val(w_q_fix));
   muldiv_negate #(.W(WIDTH)) u_fix_r (
      .i_neg(r_sa), .i_val(r_p[2*WIDTH-1:WIDTH]), .o_val(w_r_fix));

   always_comb begin
      w_fix = r_p;
      case (r_op)
         OP_MLA:   w_fix = {1'b0, r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1:0] + r_acc};
         OP_SMULL: w_fix = {1'b0, w_prod_fix};
         OP_SDIV:  w_fix = {1'b0, w_r_fix, w_q_fix};
         default:  w_fix = r_p;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_b_zero ? S_DONE : S_RUN;
         S_RUN:   if (r_cnt == CW'(1)) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_op       <= '0;
         r_sa       <= 1'b0;
         r_sb       <= 1'b0;
         r_dz       <= 1'b0;
         r_opnd     <= '0;
         r_acc      <= '0;
         r_tag      <= '0;
         r_p        <= '0;
         r_done     <= 1'b0;
         r_lo       <= '0;
         r_hi       <= '0;
         r_tag_out  <= '0;
         r_div_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_op  <= op;
               r_tag <= tag_in;
               r_acc <= acc;
               r_sa  <= w_sgn && a[WIDTH-1];
               r_sb  <= w_sgn && b[WIDTH-1];
               r_cnt <= CW'(WIDTH);
               r_dz  <= w_b_zero;
               if (w_b_zero) begin
                  r_p <= {1'b0, a, {WIDTH{1'b0}}};
               end else begin
                  // Divisor (or multiplicand) stays put; the other operand
                  // seeds the low half of the working register.
                  r_opnd <= w_div ? w_mag_b : w_mag_a;
                  r_p    <= {{(WIDTH+1){1'b0}}, (w_div ? w_mag_a : w_mag_b)};
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt - CW'(1);
               r_p   <= w_step;
            end
            S_FIX: r_p <= w_fix;
            S_DONE: if (!flush) begin
               r_done     <= 1'b1;
               r_lo       <= r_p[WIDTH-1:0];
               r_hi       <= r_p[2*WIDTH-1:WIDTH];
               r_tag_out  <= r_tag;
               r_div_zero <= r_dz;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign result_lo = r_lo;
   assign result_hi = r_hi;
   assign tag_out   = r_tag_out;
   assign div_zero  = r_div_zero;

endmodule
